// File: rtl/layer_input_streamer.sv
// Captures either the external input vector or the zero-extended hidden vector and
// streams it out as LANES-wide beats. Optional macro SHORT_HID_STREAM_EN trims hidden-sourced streams.
module layer_input_streamer #(
   parameter int DATA_W  = 8,
   parameter int IN_LEN  = 62,
   parameter int HID_LEN = 30,
   parameter int LANES   = 8,
   localparam int NB     = (IN_LEN + LANES - 1) / LANES,
   localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       input_sel,
   input  logic                       reg_sel,
   input  logic                       start,
   input  logic [IN_LEN*DATA_W-1:0]   in,
   input  logic [HID_LEN*DATA_W-1:0]  reg_hid,
   output logic [LANES*DATA_W-1:0]    out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       busy,
   output logic                       sel_err
);

   localparam int BUF_W = NB * LANES * DATA_W;
   localparam int NBH   = (HID_LEN + LANES - 1) / LANES;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   localparam logic [IDX_W-1:0] LAST_EXT = IDX_W'(NB - 1);
`ifdef SHORT_HID_STREAM_EN
   localparam logic [IDX_W-1:0] LAST_HID = IDX_W'(NBH - 1);
`else
   localparam logic [IDX_W-1:0] LAST_HID = LAST_EXT;
`endif

   logic [0:0]       state;
   logic [IDX_W-1:0] idx_p0;
   logic [IDX_W-1:0] last_idx_p0;
   logic             sel_err_p0;
   logic [BUF_W-1:0] cap_buf;
   logic [BUF_W-1:0] ext_pad;
   logic [BUF_W-1:0] hid_pad;

   // Zero padding fills both the hidden tail and the positions past IN_LEN in the final beat.
   always_comb begin
      ext_pad = '0;
      ext_pad[IN_LEN*DATA_W-1:0] = in;
   end

   always_comb begin
      hid_pad = '0;
      hid_pad[HID_LEN*DATA_W-1:0] = reg_hid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx_p0      <= '0;
         last_idx_p0 <= '0;
         sel_err_p0  <= 1'b0;
         cap_buf     <= '0;
      end else begin
         sel_err_p0 <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (input_sel) begin
                     cap_buf     <= ext_pad;
                     last_idx_p0 <= LAST_EXT;
                     idx_p0      <= '0;
                     state       <= STREAM;
                  end else if (reg_sel) begin
                     cap_buf     <= hid_pad;
                     last_idx_p0 <= LAST_HID;
                     idx_p0      <= '0;
                     state       <= STREAM;
                  end else begin
                     sel_err_p0 <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (idx_p0 == last_idx_p0) begin
                     idx_p0 <= '0;
                     state  <= IDLE;
                  end else begin
                     idx_p0 <= idx_p0 + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Beat selection is a plain mux of the capture buffer so data holds while stalled.
   always_comb begin
      out_data = '0;
      for (int l = 0; l < LANES; l++) begin
         out_data[l*DATA_W +: DATA_W] = cap_buf[(int'(idx_p0) * LANES + l) * DATA_W +: DATA_W];
      end
   end

   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);
   assign out_idx   = idx_p0;
   assign out_last  = (state == STREAM) && (idx_p0 == last_idx_p0);
   assign sel_err   = sel_err_p0;

endmodule

// File: tb/tb_layer_input_streamer.sv
// Bench for layer_input_streamer: table of directed streams, hand-written reset/error
// sequences and randomized streams checked against an element-level reference model.
module tb_layer_input_streamer;
   localparam int DATA_W  = 8;
   localparam int IN_LEN  = 62;
   localparam int HID_LEN = 30;
   localparam int LANES   = 8;
   localparam int NB      = (IN_LEN + LANES - 1) / LANES;
   localparam int IDX_W   = (NB > 1) ? $clog2(NB) : 1;
`ifdef SHORT_HID_STREAM_EN
   localparam int NB_HID  = (HID_LEN + LANES - 1) / LANES;
`else
   localparam int NB_HID  = NB;
`endif

   logic                      clk, rst, input_sel, reg_sel, start, out_ready;
   logic [IN_LEN*DATA_W-1:0]  in_v;
   logic [HID_LEN*DATA_W-1:0] reg_v;
   logic [LANES*DATA_W-1:0]   out_data;
   logic                      out_valid, out_last, busy, sel_err;
   logic [IDX_W-1:0]          out_idx;

   layer_input_streamer #(.DATA_W(DATA_W), .IN_LEN(IN_LEN), .HID_LEN(HID_LEN), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .input_sel(input_sel), .reg_sel(reg_sel), .start(start),
      .in(in_v), .reg_hid(reg_v), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_idx(out_idx), .busy(busy),
      .sel_err(sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit [7:0] m_ext [IN_LEN];
   bit [7:0] m_hid [HID_LEN];
   logic [LANES*DATA_W-1:0] got_beats [16];

   typedef struct {
      bit isel;
      bit rsel;
      int fill;
      int rdy_mode;
      bit mid;
      int exp_beats;
      bit exp_err;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: the stream is the selected vector, zero-extended, cut into LANES-wide beats.
   function automatic logic [LANES*DATA_W-1:0] exp_beat(input bit src_ext, input int b);
      logic [LANES*DATA_W-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         int e;
         e = b * LANES + l;
         if (e < IN_LEN) begin
            if (src_ext) r[l*DATA_W +: DATA_W] = m_ext[e];
            else if (e < HID_LEN) r[l*DATA_W +: DATA_W] = m_hid[e];
         end
      end
      return r;
   endfunction

   task automatic fill(input int kind);
      for (int i = 0; i < IN_LEN; i++)
         m_ext[i] = (kind == 0) ? 8'(i + 1) : (kind == 2) ? 8'h11 : 8'($urandom);
      for (int i = 0; i < HID_LEN; i++)
         m_hid[i] = (kind == 1) ? 8'(8'hA0 + i) : (kind == 2) ? 8'h22 : 8'($urandom);
      for (int i = 0; i < IN_LEN; i++) in_v[i*DATA_W +: DATA_W] = m_ext[i];
      for (int i = 0; i < HID_LEN; i++) reg_v[i*DATA_W +: DATA_W] = m_hid[i];
   endtask

   task automatic scramble();
      for (int i = 0; i < IN_LEN; i++) in_v[i*DATA_W +: DATA_W] = 8'($urandom);
      for (int i = 0; i < HID_LEN; i++) reg_v[i*DATA_W +: DATA_W] = 8'($urandom);
   endtask

   // Entered and left on a falling edge.
   task automatic do_stream(input bit isel, input bit rsel, input int rdy_mode, input bit mid,
                            output int nbeats);
      int n, b, cyc;
      bit rdy;
      n = isel ? NB : NB_HID;
      input_sel = isel;
      reg_sel   = rsel;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      b = 0;
      cyc = 0;
      while (b < n && cyc < 300) begin
         got_beats[b] = out_data;
         chk("valid", out_valid, 1);
         chk("busy", busy, 1);
         chk("idx", out_idx, b);
         chk("data", out_data, exp_beat(isel, b));
         chk("last", out_last, (b == n - 1));
         chk("sel_err_stream", sel_err, 0);
         case (rdy_mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = ($urandom_range(0, 2) != 0);
         endcase
         out_ready = rdy;
         if (mid) begin
            start     = 1'($urandom);
            input_sel = 1'($urandom);
            reg_sel   = 1'($urandom);
            scramble();
         end
         @(posedge clk);
         if (rdy) b++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      input_sel = 1'b0;
      reg_sel = 1'b0;
      out_ready = 1'b0;
      chk("stream_done", b, n);
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_last", out_last, 0);
      chk("idle_sel_err", sel_err, 0);
      nbeats = b;
   endtask

   task automatic do_err();
      input_sel = 1'b0;
      reg_sel   = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("sel_err_pulse", sel_err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("sel_err_clear", sel_err, 0);
      chk("err_busy2", busy, 0);
   endtask

   initial begin
      int nb_got;
      tbl[0] = '{1, 0, 0, 0, 0, NB, 0};
      tbl[1] = '{0, 1, 1, 0, 0, NB_HID, 0};
      tbl[2] = '{1, 1, 2, 0, 0, NB, 0};
      tbl[3] = '{1, 0, 3, 1, 1, NB, 0};
      tbl[4] = '{0, 0, 0, 0, 0, 0, 1};
      tbl[5] = '{0, 1, 3, 2, 1, NB_HID, 0};

      rst = 1'b1; input_sel = 1'b0; reg_sel = 1'b0; start = 1'b0; out_ready = 1'b0;
      in_v = '0; reg_v = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last", out_last, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_sel_err", sel_err, 0);
      chk("rst_data", out_data, 0);
      rst = 1'b0;

      for (int t = 0; t < 6; t++) begin
         fill(tbl[t].fill);
         if (tbl[t].exp_err) begin
            do_err();
         end else begin
            do_stream(tbl[t].isel, tbl[t].rsel, tbl[t].rdy_mode, tbl[t].mid, nb_got);
            chk("tbl_beats", nb_got, tbl[t].exp_beats);
         end
         if (t == 0) begin
            chk("ext_beat0", got_beats[0], 64'h0807060504030201);
            chk("ext_beat7", got_beats[7], 64'h00003E3D3C3B3A39);
         end
         if (t == 1) begin
            chk("hid_beat3", got_beats[3], 64'h0000BDBCBBBAB9B8);
`ifndef SHORT_HID_STREAM_EN
            chk("hid_beat5", got_beats[5], 64'h0);
`endif
         end
         if (t == 2) begin
            for (int k = 0; k < NB - 1; k++) chk("both_beat", got_beats[k], 64'h1111111111111111);
            chk("both_last", got_beats[NB-1], 64'h0000111111111111);
         end
      end

      // Reset in the middle of a stream.
      fill(0);
      input_sel = 1'b1; out_ready = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; input_sel = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("pre_rst_idx", out_idx, 3);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_idx", out_idx, 0);
      chk("abort_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_valid", out_valid, 0);
      end
      out_ready = 1'b0;

      for (int r = 0; r < 15; r++) begin
         int s;
         bit isel, rsel;
         s = $urandom_range(0, 2);
         isel = (s != 1);
         rsel = (s != 0);
         fill(3);
         do_stream(isel, rsel, 2, 1, nb_got);
         chk("rand_beats", nb_got, isel ? NB : NB_HID);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/layer_input_streamer.md
LAYER_INPUT_STREAMER -- requirements
Module: layer_input_streamer

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameters: IN_LEN, default 62, external input vector length in elements.
REQ-003 SHALL have parameters: HID_LEN, default 30, hidden-register vector length in elements; HID_LEN <= IN_LEN.
REQ-004 SHALL have parameters: LANES, default 8, elements per output beat.
REQ-005 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-006 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: input_sel  input  1  select external input vector.
REQ-008 SHALL have ports: reg_sel  input  1  select hidden-register vector.
REQ-009 SHALL have ports: start  input  1  request capture and stream of the selected vector.
REQ-010 SHALL have ports: in  input  IN_LEN*DATA_W  external vector; element i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have ports: reg_hid  input  HID_LEN*DATA_W  hidden vector, same element packing.
REQ-012 SHALL have ports: out_data  output  LANES*DATA_W  current beat; lane l = element b*LANES+l.
REQ-013 SHALL have ports: out_valid  output  1  out_data valid.
REQ-014 SHALL have ports: out_ready  input  1  downstream accepts beat.
REQ-015 SHALL have ports: out_last  output  1  current beat is final beat.
REQ-016 SHALL have ports: out_idx  output  clog2(NB) (min 1)  current beat index b.
REQ-017 SHALL have ports: busy  output  1  capture buffer owned, stream in progress.
REQ-018 SHALL have ports: sel_err  output  1  one-cycle pulse on start with neither select.

Function
REQ-019 SHALL define NB = ceil(IN_LEN/LANES); 62/8 -> 8 beats.
REQ-020 SHALL use states IDLE and STREAM only.
REQ-021 IDLE: start=1 with input_sel=1 SHALL capture in into buffer; input_sel has priority over reg_sel.
REQ-022 IDLE: start=1, input_sel=0, reg_sel=1 SHALL capture reg_hid into elements 0..HID_LEN-1, zeros into HID_LEN..IN_LEN-1.
REQ-023 Capture SHALL occur on the accepting edge; STREAM, out_valid=1, out_idx=0, busy=1 visible the following cycle.
REQ-024 IDLE: start=1 with both selects 0 SHALL stay IDLE and pulse sel_err for exactly one cycle.
REQ-025 Buffer positions >= IN_LEN within the final beat SHALL read zero.
REQ-026 STREAM: out_valid SHALL stay 1 and out_data/out_idx SHALL hold stable until out_valid&&out_ready.
REQ-027 Handshake on beat b < last SHALL advance to b+1 next cycle; no idle gap.
REQ-028 out_last SHALL be 1 exactly when out_idx equals final beat index and out_valid=1.
REQ-029 Handshake on last beat SHALL return to IDLE; out_valid, busy, out_last 0 next cycle.
REQ-030 start, in, reg_hid SHALL be ignored while busy=1 (including the last-beat handshake cycle); no sel_err.
REQ-031 Buffer contents SHALL be unaffected by changes on in/reg_hid after capture.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, out_valid=0, out_last=0, out_idx=0, busy=0, sel_err=0, out_data=0, buffer=0.
REQ-033 rst asserted mid-stream SHALL abort the stream; no further beats after release until new start.
REQ-034 First start SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-035 Macro SHORT_HID_STREAM_EN defined: hidden-sourced stream SHALL use NBH = ceil(HID_LEN/LANES) beats (30/8 -> 4), out_last on beat NBH-1.
REQ-036 SHORT_HID_STREAM_EN undefined: hidden-sourced stream SHALL use NB beats, trailing beats all zero; external-sourced streams unaffected either way.

Verification
REQ-037 in element i = i+1, input_sel=1, start pulse, out_ready=1 -> 8 consecutive beats, beat 0 = 1..8, beat 7 = 57..62,0,0, out_last on beat 7 only.
REQ-038 reg_hid element i = 0xA0+i, reg_sel=1 -> beat 3 = 0xB8..0xBD,0,0; without macro beats 4..7 zero and last at 7; with macro last at beat 3.
REQ-039 Both selects 1 with in=0x11s, reg_hid=0x22s -> all beats carry 0x11.
REQ-040 out_ready toggled 1,0,0,1 pattern -> beats held stable while stalled, none dropped or duplicated, start pulsed mid-stream ignored.
REQ-041 start with both selects 0 -> sel_err high one cycle, busy stays 0; rst pulse at beat 3 -> out_valid 0 immediately, IDLE after release.
